soc_system_stepper_step_gen: RTL and testbench

//   Sequences one stepper axis from the signed step-count command register.
//   On a start strobe it latches the signed count, drives DIR, then emits |count|

---
 rtl/soc_system_stepper_step_gen_pkg.sv | 12 +
 rtl/soc_system_stepper_step_gen_timer.sv | 27 ++
 rtl/soc_system_stepper_step_gen.sv | 147 ++++++++++++++
 tb/tb_soc_system_stepper_step_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_stepper_step_gen_pkg.sv
// Shared definitions for the stepper step generator: FSM state encodings.
package soc_system_stepper_step_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/soc_system_stepper_step_gen_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases.
module soc_system_stepper_step_gen_timer #(
   parameter int TIM_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [TIM_W-1:0] load_val,
   output logic             zero
);

   logic [TIM_W-1:0] count;

   // Load wins over counting; the counter parks at zero between phases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - TIM_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/soc_system_stepper_step_gen.sv
// Single-axis stepper sequencer: latches a signed move, drives DIR, then emits
// |steps| STEP pulses with programmable high/low widths.
module soc_system_stepper_step_gen
   import soc_system_stepper_step_gen_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int TIM_W     = 16,
   parameter int DIR_SETUP = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] steps,
   input  logic [TIM_W-1:0] high_cycles,
   input  logic [TIM_W-1:0] low_cycles,
   output logic             step_out,
   output logic             dir_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   state_t           state;
   logic [TIM_W-1:0] hi_w;
   logic [TIM_W-1:0] lo_w;
   logic [CNT_W-1:0] mag;
   logic             accept;
   logic             setup_end;
   logic             high_end;
   logic             low_end;
   logic             timer_load;
   logic [TIM_W-1:0] timer_val;
   logic             timer_zero;

   // Two's-complement magnitude; the most negative value maps onto 2^(CNT_W-1).
   assign mag       = steps[CNT_W-1] ? (~steps + CNT_W'(1)) : steps;
   assign accept    = (state == ST_IDLE)  && start && !abort;
   assign setup_end = (state == ST_SETUP) && !abort && timer_zero;
   assign high_end  = (state == ST_HIGH)  && !abort && timer_zero;
   assign low_end   = (state == ST_LOW)   && !abort && timer_zero;

   // The timer is reloaded with width-1 on the same edge that enters each timed phase.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      if (accept) begin
         timer_load = 1'b1;
         timer_val  = TIM_W'(DIR_SETUP - 1);
      end else if (setup_end || (low_end && (remaining != '0))) begin
         timer_load = 1'b1;
         timer_val  = hi_w - TIM_W'(1);
      end else if (high_end) begin
         timer_load = 1'b1;
         timer_val  = lo_w - TIM_W'(1);
      end
   end

   soc_system_stepper_step_gen_timer #(
      .TIM_W (TIM_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         step_out  <= 1'b0;
         dir_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         hi_w      <= TIM_W'(1);
         lo_w      <= TIM_W'(1);
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  hi_w      <= (high_cycles == '0) ? TIM_W'(1) : high_cycles;
                  lo_w      <= (low_cycles == '0) ? TIM_W'(1) : low_cycles;
                  dir_out   <= steps[CNT_W-1];
                  remaining <= mag;
                  busy      <= 1'b1;
                  if (mag == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               if (abort) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  step_out <= 1'b0;
               end else if (timer_zero) begin
                  state    <= ST_HIGH;
                  step_out <= 1'b1;
               end
            end
            ST_HIGH: begin
               // An aborted high phase is not counted as an issued step.
               if (abort) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  step_out <= 1'b0;
               end else if (timer_zero) begin
                  state     <= ST_LOW;
                  step_out  <= 1'b0;
                  remaining <= remaining - CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (abort) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  step_out <= 1'b0;
               end else if (timer_zero) begin
                  if (remaining == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ST_HIGH;
                     step_out <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               step_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_stepper_step_gen.sv
// Self-checking bench for soc_system_stepper_step_gen: table-driven moves with a scoreboard plus hand sequences.
module tb_soc_system_stepper_step_gen;

   localparam int CNT_W = 32;
   localparam int TIM_W = 16;
   localparam int DS    = 4;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] steps;
   logic [TIM_W-1:0] high_cycles;
   logic [TIM_W-1:0] low_cycles;
   logic             step_out;
   logic             dir_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;

   soc_system_stepper_step_gen #(
      .CNT_W     (CNT_W),
      .TIM_W     (TIM_W),
      .DIR_SETUP (DS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .steps       (steps),
      .high_cycles (high_cycles),
      .low_cycles  (low_cycles),
      .step_out    (step_out),
      .dir_out     (dir_out),
      .busy        (busy),
      .done        (done),
      .remaining   (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] steps;
      int          hi;
      int          lo;
      int          restart_k;
      int          exp_dir;
      int          exp_pulses;
   } vec_t;

   typedef struct {
      int dir;
      int rem0;
      int pulses;
      int first_rise;
      int hi_len;
      int period;
      int done_cnt;
      int done_k;
      int busy_len;
      int seq_err;
      int dir_err;
   } obs_t;

   vec_t vecs[7];
   obs_t sb_q[$];
   int   total;
   int   bad;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkField(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Drives one move and pushes the timing the spec predicts for it.
   task automatic applyStimulus(input vec_t v);
      obs_t e;
      int   hp;
      int   lp;
      int   n;
      @(negedge clk);
      steps       = v.steps;
      high_cycles = TIM_W'(v.hi);
      low_cycles  = TIM_W'(v.lo);
      abort       = 1'b0;
      start       = 1'b1;
      hp = (v.hi == 0) ? 1 : v.hi;
      lp = (v.lo == 0) ? 1 : v.lo;
      n  = v.exp_pulses;
      e = '{default: 0};
      e.dir        = v.exp_dir;
      e.rem0       = n;
      e.pulses     = n;
      e.first_rise = (n > 0) ? DS + 1 : 0;
      e.hi_len     = (n > 0) ? hp : 0;
      e.period     = (n > 1) ? hp + lp : 0;
      e.done_cnt   = 1;
      e.done_k     = (n > 0) ? DS + n * (hp + lp) + 1 : 1;
      e.busy_len   = e.done_k;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      start       = 1'b0;
      steps       = $urandom;
      high_cycles = TIM_W'($urandom);
      low_cycles  = TIM_W'($urandom);
   endtask

   task automatic observeMove(input int restart_k, output obs_t o);
      int  last_rise;
      int  d;
      logic prev_step;
      o = '{default: 0};
      last_rise = 0;
      prev_step = 1'b0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (k == 1) begin
            o.dir  = int'(dir_out);
            o.rem0 = int'(remaining);
         end else if (busy && (int'(dir_out) != o.dir)) begin
            o.dir_err++;
         end
         if (busy) o.busy_len++;
         if (step_out && !prev_step) begin
            o.pulses++;
            if (o.pulses == 1) begin
               o.first_rise = k;
            end else begin
               d = k - last_rise;
               if (o.period == 0) o.period = d;
               else if (o.period != d) o.period = -1;
            end
            last_rise = k;
         end
         if (!step_out && prev_step) begin
            d = k - last_rise;
            if (o.hi_len == 0) o.hi_len = d;
            else if (o.hi_len != d) o.hi_len = -1;
            if (int'(remaining) != o.rem0 - o.pulses) o.seq_err++;
         end
         if (done) begin
            o.done_cnt++;
            o.done_k = k;
            if (step_out || !busy) o.seq_err++;
         end
         prev_step = step_out;
         if (k == restart_k) begin
            start = 1'b1;
            steps = 32'd7;
         end else begin
            start = 1'b0;
         end
         if ((o.done_cnt > 0) && !busy) break;
      end
      start = 1'b0;
   endtask

   task automatic checkOutput(input int idx, input obs_t o);
      obs_t e;
      checkField($sformatf("row%0d_scoreboard", idx), sb_q.size(), 1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      checkField($sformatf("row%0d_dir", idx), o.dir, e.dir);
      checkField($sformatf("row%0d_rem0", idx), o.rem0, e.rem0);
      checkField($sformatf("row%0d_pulses", idx), o.pulses, e.pulses);
      checkField($sformatf("row%0d_first_rise", idx), o.first_rise, e.first_rise);
      checkField($sformatf("row%0d_hi_len", idx), o.hi_len, e.hi_len);
      checkField($sformatf("row%0d_period", idx), o.period, e.period);
      checkField($sformatf("row%0d_done_cnt", idx), o.done_cnt, e.done_cnt);
      checkField($sformatf("row%0d_done_k", idx), o.done_k, e.done_k);
      checkField($sformatf("row%0d_busy_len", idx), o.busy_len, e.busy_len);
      checkField($sformatf("row%0d_seq_err", idx), o.seq_err, 0);
      checkField($sformatf("row%0d_dir_err", idx), o.dir_err, 0);
   endtask

   initial begin
      obs_t o;
      int   rises;
      logic prev;
      total = 0;
      bad   = 0;

      vecs[0] = '{32'd3,          2, 3, 0, 0, 3};
      vecs[1] = '{32'hFFFF_FFFE,  2, 2, 0, 1, 2};
      vecs[2] = '{32'd1,          1, 2, 0, 0, 1};
      vecs[3] = '{32'd0,          2, 2, 0, 0, 0};
      vecs[4] = '{32'd2,          0, 0, 0, 0, 2};
      vecs[5] = '{32'd2,          1, 1, 3, 0, 2};
      vecs[6] = '{32'hFFFF_FFFD,  3, 1, 0, 1, 3};

      reset_n     = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      steps       = '0;
      high_cycles = '0;
      low_cycles  = '0;
      #12;
      checkField("reset_step", step_out, 0);
      checkField("reset_dir", dir_out, 0);
      checkField("reset_busy", busy, 0);
      checkField("reset_done", done, 0);
      checkField("reset_rem", remaining, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         observeMove(vecs[i].restart_k, o);
         checkOutput(i, o);
         repeat (2) @(negedge clk);
      end

      // start together with abort in IDLE must not launch a move
      @(negedge clk);
      steps = 32'd4; high_cycles = 16'd1; low_cycles = 16'd1;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checkField("startabort_busy", busy, 0);
      checkField("startabort_rem", remaining, 0);
      checkField("startabort_dir", dir_out, 1);
      rises = 0;
      prev  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (step_out && !prev) rises++;
         if (busy) rises++;
         prev = step_out;
      end
      checkField("startabort_activity", rises, 0);

      // abort in the second high cycle of pulse 3
      @(negedge clk);
      steps = 32'd10; high_cycles = 16'd4; low_cycles = 16'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      rises = 0;
      prev  = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (step_out && !prev) rises++;
         prev = step_out;
         if (k == 21) begin
            checkField("abort_k21_step", step_out, 1);
            checkField("abort_k21_rem", remaining, 8);
         end
         if (k == 22) begin
            checkField("abort_k22_step", step_out, 1);
            abort = 1'b1;
         end
         if (k == 23) begin
            checkField("abort_k23_step", step_out, 0);
            checkField("abort_k23_done", done, 1);
            checkField("abort_k23_busy", busy, 1);
            checkField("abort_k23_rem", remaining, 8);
         end
         if (k == 24) begin
            abort = 1'b0;
            checkField("abort_k24_busy", busy, 0);
            checkField("abort_k24_done", done, 0);
            checkField("abort_k24_rem", remaining, 8);
         end
      end
      checkField("abort_pulses", rises, 3);

      // most negative count, aborted during SETUP
      repeat (2) @(negedge clk);
      steps = 32'h8000_0000; high_cycles = 16'd1; low_cycles = 16'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkField("minneg_rem", remaining, 64'h8000_0000);
      checkField("minneg_dir", dir_out, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkField("minneg_done", done, 1);
      checkField("minneg_step", step_out, 0);
      checkField("minneg_rem_frozen", remaining, 64'h8000_0000);

      // asynchronous reset during HIGH
      repeat (3) @(negedge clk);
      steps = 32'hFFFF_FFFB; high_cycles = 16'd3; low_cycles = 16'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      checkField("rst_pre_step", step_out, 1);
      #2 reset_n = 1'b0;
      #1;
      checkField("rst_step", step_out, 0);
      checkField("rst_busy", busy, 0);
      checkField("rst_rem", remaining, 0);
      checkField("rst_dir", dir_out, 0);
      checkField("rst_done", done, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus('{32'd1, 2, 2, 0, 0, 1});
      observeMove(0, o);
      checkOutput(7, o);

      checkField("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
